// File: rtl/vga_fetch_pkg.sv
// Shared types, default geometry and helpers for the VGA line-prefetch scheduler.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_e;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_BURST_LEN  = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 64;
    localparam int unsigned DEF_ADDR_W     = 20;
    localparam int unsigned DEF_BASE_ADDR  = 0;

    localparam int unsigned FRAME_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

    // Level counters need one extra bit so that a completely full FIFO is representable.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned LVL_W = lvl_w(DEF_FIFO_DEPTH);

    function automatic int unsigned min_len(input int unsigned remaining, input int unsigned burst);
        return (remaining < burst) ? remaining : burst;
    endfunction

endpackage

// File: rtl/vga_fetch_sched_if.sv
// Burst read request channel between the fetch scheduler (master) and the frame-memory arbiter (slave).
interface vga_fetch_sched_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_beat;

    modport master (output rd_req, rd_addr, rd_len, input  rd_ack, rd_beat);
    modport slave  (input  rd_req, rd_addr, rd_len, output rd_ack, rd_beat);
endinterface

// File: rtl/vga_fetch_credit.sv
// FIFO fill and credit (fill + in-flight) tracking with sticky underflow detection.
// VGA_FETCH_UFLOW_CNT_EN adds a saturating underflow event counter.
module vga_fetch_credit
    import vga_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         pixel_clk,
    input  logic                         rst_n,
    input  logic                         xfer,
    input  logic [7:0]                   xfer_len,
    input  logic                         de,
    input  logic                         rd_beat,
    input  logic                         frame_start,
    output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic [lvl_w(FIFO_DEPTH)-1:0] reserved,
    output logic                         underflow
`ifdef VGA_FETCH_UFLOW_CNT_EN
    ,
    output logic [15:0]                  underflow_cnt
`endif
);
    localparam int unsigned LW = lvl_w(FIFO_DEPTH);

    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] reserved_q, reserved_d;
    logic          underflow_q, underflow_d;
    logic          pop, uflow_evt, beat_ok;

    always_comb begin
        pop         = de & (level_q != '0);
        uflow_evt   = de & (level_q == '0);
        // A beat into a full FIFO is dropped rather than wrapping the counter.
        beat_ok     = rd_beat & (level_q != LW'(FIFO_DEPTH));
        level_d     = level_q + LW'(beat_ok) - LW'(pop);
        reserved_d  = reserved_q + (xfer ? LW'(xfer_len) : '0) - LW'(pop);
        underflow_d = uflow_evt | (underflow_q & ~frame_start);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= '0;
            reserved_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            reserved_q  <= reserved_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef VGA_FETCH_UFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (uflow_evt && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) ucnt_q <= '0;
        else        ucnt_q <= ucnt_d;
    end

    assign underflow_cnt = ucnt_q;
`endif

    assign fifo_level = level_q;
    assign reserved   = reserved_q;
    assign underflow  = underflow_q;

endmodule

// File: rtl/vga_fetch_sched.sv
// Line-prefetch scheduler: issues burst reads so the external pixel FIFO stays ahead of de.
// VGA_FETCH_UFLOW_CNT_EN adds the underflow_cnt output (saturating underflow event count).
module vga_fetch_sched
    import vga_fetch_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned BASE_ADDR  = DEF_BASE_ADDR
) (
    input  logic                         pixel_clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         vs,
    input  logic                         de,
    vga_fetch_sched_if.master            rd,
    output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                         underflow,
    output logic                         busy
`ifdef VGA_FETCH_UFLOW_CNT_EN
    ,
    output logic [15:0]                  underflow_cnt
`endif
);
    localparam int unsigned       FRAME_PX  = H_ACTIVE * V_ACTIVE;
    localparam int unsigned       REM_W     = $clog2(FRAME_PX + 1);
    localparam int unsigned       LW        = lvl_w(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [REM_W-1:0]  FRAME_REM = REM_W'(FRAME_PX);

    state_e             state_q, state_d;
    logic               vs_q;
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [7:0]         rd_len_q, rd_len_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic               reload_pend_q, reload_pend_d;
    logic               busy_q;
    logic [LW-1:0]      reserved;
    logic               frame_start, xfer, fits;
    logic [7:0]         next_len;

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        frame_start   = vs_q & ~vs;
        xfer          = rd_req_q & rd.rd_ack;
        next_len      = 8'(min_len(32'(remaining_q), BURST_LEN));
        fits          = (32'(reserved) + 32'(next_len)) <= FIFO_DEPTH;
        state_d       = state_q;
        rd_req_d      = rd_req_q;
        rd_addr_d     = rd_addr_q;
        rd_len_d      = rd_len_q;
        remaining_d   = remaining_q;
        reload_pend_d = reload_pend_q;

        unique case (state_q)
            IDLE: if (enable) state_d = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    state_d     = RUN;
                    rd_addr_d   = BASE;
                    remaining_d = FRAME_REM;
                end
            end
            RUN: begin
                // A pending request always finishes first; a frame restart seen meanwhile is deferred.
                if (xfer) begin
                    rd_req_d = 1'b0;
                    if (reload_pend_q || frame_start) begin
                        rd_addr_d     = BASE;
                        remaining_d   = FRAME_REM;
                        reload_pend_d = 1'b0;
                    end else begin
                        rd_addr_d   = rd_addr_q + ADDR_W'(rd_len_q);
                        remaining_d = remaining_q - REM_W'(rd_len_q);
                    end
                end else if (rd_req_q) begin
                    if (frame_start) reload_pend_d = 1'b1;
                end else if (!enable) begin
                    state_d = IDLE;
                end else if (frame_start) begin
                    rd_addr_d   = BASE;
                    remaining_d = FRAME_REM;
                end else if (remaining_q == '0) begin
                    state_d = WAIT_FRAME;
                end else if (fits) begin
                    rd_req_d = 1'b1;
                    rd_len_d = next_len;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            vs_q          <= 1'b1;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= BASE;
            rd_len_q      <= '0;
            remaining_q   <= '0;
            reload_pend_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            rd_len_q      <= rd_len_d;
            remaining_q   <= remaining_d;
            reload_pend_q <= reload_pend_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    vga_fetch_credit #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_credit (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .xfer          (xfer),
        .xfer_len      (rd_len_q),
        .de            (de),
        .rd_beat       (rd.rd_beat),
        .frame_start   (frame_start),
        .fifo_level    (fifo_level),
        .reserved      (reserved),
        .underflow     (underflow)
`ifdef VGA_FETCH_UFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    assign rd.rd_req  = rd_req_q;
    assign rd.rd_addr = rd_addr_q;
    assign rd.rd_len  = rd_len_q;
    assign busy       = busy_q;

endmodule
